// File: rtl/fp_cmp_pack_sched.sv
// Two-requester scheduler for the shared segmented |X| < |Y| comparator, with registered
// per-requester response slots. Define FP_CMP_PACK_EN to pack two FP16 ops into one FP16x2 pass.

package fp_cmp_pkg;
    typedef enum logic {
        FMT_FP32 = 1'b0,
        FMT_FP16 = 1'b1
    } fp_fmt_e;
endpackage

// Segmented magnitude comparator. The operands carry magnitude bits only (sign bit 31 dropped).
// FP32: swaps[1] is the full 31-bit compare. FP16: swaps[0] is the lo lane, swaps[1] the hi lane.
module abs_comparator
    import fp_cmp_pkg::*;
(
    input  logic [30:0] a,
    input  logic [30:0] b,
    input  fp_fmt_e     fmt,
    output logic [1:0]  swaps
);
    logic hi_lt, hi_eq, lo16_lt, lo15_lt;

    assign hi_lt   = a[30:16] < b[30:16];
    assign hi_eq   = a[30:16] == b[30:16];
    assign lo16_lt = a[15:0] < b[15:0];
    assign lo15_lt = a[14:0] < b[14:0];

    assign swaps[0] = lo15_lt;
    assign swaps[1] = (fmt == FMT_FP16) ? hi_lt : (hi_lt || (hi_eq && lo16_lt));
endmodule

module fp_cmp_pack_sched
    import fp_cmp_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_fmt,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_fmt,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp0_swap,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp1_swap,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [CNT_W-1:0] cnt_issue,
    output logic [CNT_W-1:0] cnt_packed
);
    logic        rr_ptr;
    logic        elig0, elig1, both_elig, pack;
    logic        grant0, grant1, sel1;
    fp_fmt_e     fmt0, fmt1, sel_fmt, op_fmt;
    logic [31:0] sel_x, sel_y;
    logic [30:0] op_a, op_b;
    logic [1:0]  swaps;
    logic        single_swap, res0, res1;
    logic        unused_sign;

    assign fmt0 = fp_fmt_e'(req0_fmt);
    assign fmt1 = fp_fmt_e'(req1_fmt);

    // Gating with rst_n keeps ready low for the whole reset window, not just after an edge.
    assign elig0     = rst_n && req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1     = rst_n && req1_valid && (!rsp1_valid || rsp1_ready);
    assign both_elig = elig0 && elig1;

`ifdef FP_CMP_PACK_EN
    assign pack = both_elig && (fmt0 == FMT_FP16) && (fmt1 == FMT_FP16);
`else
    assign pack = 1'b0;
`endif

    assign grant0     = pack || (elig0 && (!elig1 || !rr_ptr));
    assign grant1     = pack || (elig1 && (!elig0 || rr_ptr));
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel1    = grant1 && !pack;
    assign sel_fmt = sel1 ? fmt1 : fmt0;
    assign sel_x   = sel1 ? req1_x : req0_x;
    assign sel_y   = sel1 ? req1_y : req0_y;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        op_fmt = sel_fmt;
        op_a   = sel_x[30:0];
        op_b   = sel_y[30:0];
        if (pack) begin
            op_fmt = FMT_FP16;
            op_a   = {req1_x[14:0], req0_x[15:0]};
            op_b   = {req1_y[14:0], req0_y[15:0]};
        end else if (sel_fmt == FMT_FP16) begin
            op_a = {15'd0, sel_x[15:0]};
            op_b = {15'd0, sel_y[15:0]};
        end
    end

    abs_comparator u_cmp (
        .a    (op_a),
        .b    (op_b),
        .fmt  (op_fmt),
        .swaps(swaps)
    );

    assign single_swap = (op_fmt == FMT_FP32) ? swaps[1] : swaps[0];
    assign res0        = pack ? swaps[0] : single_swap;
    assign res1        = pack ? swaps[1] : single_swap;

    // Sign bits never influence a magnitude compare.
    assign unused_sign = ^{req0_x[31], req0_y[31], req1_x[31], req1_y[31]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_swap  <= 1'b0;
            rsp0_tag   <= '0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_swap  <= res0;
            rsp0_tag   <= req0_tag;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_swap  <= 1'b0;
            rsp1_tag   <= '0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_swap  <= res1;
            rsp1_tag   <= req1_tag;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves only when a contended single grant was made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            cnt_issue <= '0;
        end else begin
            if (both_elig && !pack) rr_ptr <= !rr_ptr;
            if ((grant0 || grant1) && (cnt_issue != '1)) cnt_issue <= cnt_issue + CNT_W'(1);
        end
    end

`ifdef FP_CMP_PACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_packed <= '0;
        end else if (pack && (cnt_packed != '1)) begin
            cnt_packed <= cnt_packed + CNT_W'(1);
        end
    end
`else
    assign cnt_packed = '0;
`endif
endmodule

// File: tb/tb_fp_cmp_pack_sched.sv
// Scoreboard bench for fp_cmp_pack_sched: expected results queued per requester on grant,
// compared when the response slot pops.
module tb_fp_cmp_pack_sched;
    import fp_cmp_pkg::*;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             swap;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_fmt;
    logic [31:0]      req0_x, req0_y;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_fmt;
    logic [31:0]      req1_x, req1_y;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp0_valid, rsp0_ready, rsp0_swap;
    logic [TAG_W-1:0] rsp0_tag;
    logic             rsp1_valid, rsp1_ready, rsp1_swap;
    logic [TAG_W-1:0] rsp1_tag;
    logic [CNT_W-1:0] cnt_issue, cnt_packed;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_issue = 0;
    int   exp_packed = 0;
    logic rr = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    fp_cmp_pack_sched #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fmt(req0_fmt),
        .req0_x(req0_x), .req0_y(req0_y), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fmt(req1_fmt),
        .req1_x(req1_x), .req1_y(req1_y), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_swap(rsp0_swap), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_swap(rsp1_swap), .rsp1_tag(rsp1_tag),
        .cnt_issue(cnt_issue), .cnt_packed(cnt_packed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: sign-free magnitude compare on the operand bits the format actually uses.
    function automatic logic model_swap(input logic fmt, input logic [31:0] x, input logic [31:0] y);
        if (fmt == FMT_FP32) return x[30:0] < y[30:0];
        return x[14:0] < y[14:0];
    endfunction

    task automatic drive0(input logic f, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
        req0_valid = 1'b1; req0_fmt = f; req0_x = x; req0_y = y; req0_tag = t;
    endtask

    task automatic drive1(input logic f, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
        req1_valid = 1'b1; req1_fmt = f; req1_x = x; req1_y = y; req1_tag = t;
    endtask

    // One clock: check readies, pop/compare responses, queue expected results, advance.
    task automatic cycle(input logic er0, input logic er1);
        exp_t e;
        #1;
        check("req0_ready", req0_ready, er0);
        check("req1_ready", req1_ready, er1);
        if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) check("rsp0_extra", q0.size(), 1);
            else begin
                e = q0.pop_front();
                check("rsp0_swap", rsp0_swap, e.swap);
                check("rsp0_tag", rsp0_tag, e.tag);
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) check("rsp1_extra", q1.size(), 1);
            else begin
                e = q1.pop_front();
                check("rsp1_swap", rsp1_swap, e.swap);
                check("rsp1_tag", rsp1_tag, e.tag);
            end
        end
        if (er0) q0.push_back(exp_t'{swap: model_swap(req0_fmt, req0_x, req0_y), tag: req0_tag});
        if (er1) q1.push_back(exp_t'{swap: model_swap(req1_fmt, req1_x, req1_y), tag: req1_tag});
        if (er0 || er1) exp_issue++;
        if (er0 && er1) exp_packed++;
        @(posedge clk);
        @(negedge clk);
        if (er0) req0_valid = 1'b0;
        if (er1) req1_valid = 1'b0;
    endtask

    task automatic chk_cnt();
        check("cnt_issue", cnt_issue, exp_issue);
        check("cnt_packed", cnt_packed, exp_packed);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_fmt = FMT_FP32; req0_x = '0; req0_y = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_fmt = FMT_FP32; req1_x = '0; req1_y = '0; req1_tag = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state, with a request presented that must not be accepted.
        drive0(FMT_FP32, 32'h3F80_0000, 32'h4000_0000, 4'h7);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_swap", rsp0_swap, 0);
        check("rst_rsp0_tag", rsp0_tag, 0);
        check("rst_rsp1_tag", rsp1_tag, 0);
        chk_cnt();
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single FP32: 1.0 vs 2.0 swaps.
        drive0(FMT_FP32, 32'h3F80_0000, 32'h4000_0000, 4'h1);
        cycle(1, 0);
        check("t1_rsp0_valid", rsp0_valid, 1);
        cycle(0, 0);
        chk_cnt();

        // Two FP16 ops in the same cycle.
        drive0(FMT_FP16, 32'h0000_3C00, 32'h0000_4000, 4'h2);
        drive1(FMT_FP16, 32'h0000_C200, 32'h0000_3C00, 4'h3);
`ifdef FP_CMP_PACK_EN
        cycle(1, 1);
`else
        cycle(1, 0);
        rr = 1'b1;
        cycle(0, 1);
`endif
        cycle(0, 0);
        chk_cnt();

        // Contended FP32 stream held valid for four cycles: strict alternation.
        for (int i = 0; i < 4; i++) begin
            if (!req0_valid) drive0(FMT_FP32, 32'h4040_0000 + i, 32'h3F80_0000, 4'(i));
            if (!req1_valid) drive1(FMT_FP32, 32'h0000_0001 + i, 32'h8000_0005 + i, 4'(8 + i));
            cycle(!rr, rr);
            rr = !rr;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle(0, 0);
        chk_cnt();

        // Equal magnitudes in mixed formats (never packed); FP16 upper bits are garbage.
        drive0(FMT_FP32, 32'h3F80_0000, 32'hBF80_0000, 4'h9);
        drive1(FMT_FP16, 32'hABCD_8001, 32'h1234_0001, 4'hA);
        if (!rr) begin
            cycle(1, 0);
            cycle(0, 1);
        end else begin
            cycle(0, 1);
            cycle(1, 0);
        end
        rr = !rr;
        drive1(FMT_FP16, 32'h7FFF_0001, 32'h0000_0002, 4'hB);
        cycle(0, 1);
        cycle(0, 0);

        // Slot 0 held full: req0 stalls, req1 goes alone even though both are FP16.
        rsp0_ready = 1'b0;
        drive0(FMT_FP16, 32'h0000_3C00, 32'h0000_4000, 4'hC);
        cycle(1, 0);
        drive0(FMT_FP16, 32'h0000_5000, 32'h0000_1000, 4'hD);
        drive1(FMT_FP16, 32'hFFFF_3C00, 32'hFFFF_4200, 4'hE);
        cycle(0, 1);
        check("hold_valid", rsp0_valid, 1);
        check("hold_swap", rsp0_swap, 1);
        check("hold_tag", rsp0_tag, 4'hC);
        cycle(0, 0);
        check("hold_swap2", rsp0_swap, 1);
        check("hold_tag2", rsp0_tag, 4'hC);
        rsp0_ready = 1'b1;
        cycle(1, 0);
        cycle(0, 0);
        chk_cnt();

        // Fill both slots, then reset asynchronously mid-cycle.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(FMT_FP32, 32'h0000_0001, 32'h0000_0002, 4'h1);
        cycle(1, 0);
        drive1(FMT_FP32, 32'h0000_0005, 32'h0000_0003, 4'h2);
        cycle(0, 1);
        check("full_rsp0_valid", rsp0_valid, 1);
        check("full_rsp1_valid", rsp1_valid, 1);
        rst_n = 1'b0;
        drive0(FMT_FP32, 32'h0000_0001, 32'h0000_0002, 4'h3);
        #2;
        check("arst_rsp0_valid", rsp0_valid, 0);
        check("arst_rsp1_valid", rsp1_valid, 0);
        check("arst_req0_ready", req0_ready, 0);
        q0.delete();
        q1.delete();
        exp_issue = 0;
        exp_packed = 0;
        rr = 1'b0;
        chk_cnt();
        @(posedge clk);
        @(negedge clk);
        check("arst_req0_ready2", req0_ready, 0);
        check("arst_cnt_issue2", cnt_issue, 0);
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        drive1(FMT_FP32, 32'h3F80_0000, 32'h4000_0000, 4'hF);
        cycle(0, 1);
        cycle(0, 0);
        chk_cnt();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
